// File: rtl/img_stream_tx.sv
// Packs a pixel stream PIX_PER_BEAT pixels per beat and sends each frame as AXI4-Stream.
// TUSER flags the first beat, TLAST the beat holding the final pixel, and done pulses after TLAST is accepted.
module img_stream_tx #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_BEAT = 4,
  parameter int DIM_W        = 12
) (
  input  logic                                role_clk,
  input  logic                                role_rst,
  input  logic                                start,
  input  logic [DIM_W-1:0]                    frame_width,
  input  logic [DIM_W-1:0]                    frame_height,
  output logic                                busy,
  output logic                                done,
  input  logic [PIX_W-1:0]                    pix_data,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  output logic [PIX_W*PIX_PER_BEAT-1:0]       m_axis_tdata,
  output logic [PIX_W*PIX_PER_BEAT/8-1:0]     m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tuser
);
  localparam int KEEP_W = PIX_W*PIX_PER_BEAT/8;
  localparam int BPL    = PIX_W/8;
  localparam int LANE_W = $clog2(PIX_PER_BEAT);
  localparam int CNT_W  = 2*DIM_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]                        total, pix_cnt, start_total;
  logic [LANE_W-1:0]                       lane;
  logic [PIX_PER_BEAT-1:0][PIX_W-1:0]      accum, beat_word;
  logic [KEEP_W-1:0]                       beat_keep;
  logic                                    first_beat, pix_fire, last_pix, beat_done, out_fire;

  assign start_total = CNT_W'(frame_width) * CNT_W'(frame_height);
  assign pix_ready   = (state == RUN) && (!m_axis_tvalid || m_axis_tready);
  assign pix_fire    = pix_valid && pix_ready;
  assign last_pix    = (pix_cnt == total - CNT_W'(1));
  assign beat_done   = pix_fire && ((lane == LANE_W'(PIX_PER_BEAT-1)) || last_pix);
  assign out_fire    = m_axis_tvalid && m_axis_tready;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  // Lanes above the current one are already zero because accum clears on every beat.
  always_comb begin
    beat_word       = accum;
    beat_word[lane] = pix_data;
    beat_keep       = '0;
    for (int b = 0; b < KEEP_W; b++) beat_keep[b] = ((b / BPL) <= int'(lane));
  end

  // An empty frame passes through DRAIN so busy is visible for one cycle before done.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (start_total == '0) ? DRAIN : RUN;
      RUN:     if (pix_fire && last_pix) state_nxt = DRAIN;
      DRAIN:   if (!m_axis_tvalid || out_fire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge role_clk or posedge role_rst) begin
    if (role_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge role_clk or posedge role_rst) begin
    if (role_rst) begin
      total         <= '0;
      pix_cnt       <= '0;
      lane          <= '0;
      accum         <= '0;
      first_beat    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        total      <= start_total;
        pix_cnt    <= '0;
        lane       <= '0;
        accum      <= '0;
        first_beat <= 1'b1;
      end
      if (pix_fire) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
        if (beat_done) begin
          lane  <= '0;
          accum <= '0;
        end else begin
          lane        <= lane + LANE_W'(1);
          accum[lane] <= pix_data;
        end
      end
      // A new beat may load on the same edge the previous one is accepted.
      if (beat_done) begin
        m_axis_tdata  <= beat_word;
        m_axis_tkeep  <= beat_keep;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_pix;
        m_axis_tuser  <= first_beat;
        first_beat    <= 1'b0;
      end else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_img_stream_tx.sv
// Directed and randomized frames checked against a queue-based beat model.
module tb_img_stream_tx;
  localparam int PIX_W = 8, PPB = 4, DIM_W = 12;
  localparam int DW = PIX_W*PPB, KW = DW/8;

  logic              role_clk = 1'b0, role_rst = 1'b1;
  logic              start = 1'b0, busy, done;
  logic [DIM_W-1:0]  frame_width = '0, frame_height = '0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              pix_valid = 1'b0, pix_ready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, m_axis_tuser;

  img_stream_tx #(.PIX_W(PIX_W), .PIX_PER_BEAT(PPB), .DIM_W(DIM_W)) dut (
    .role_clk(role_clk), .role_rst(role_rst), .start(start),
    .frame_width(frame_width), .frame_height(frame_height),
    .busy(busy), .done(done),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  always #5 role_clk = ~role_clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  beat_t            exp_q[$];
  logic [PIX_W-1:0] pix_q[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"},  m_axis_tdata, 0);
    chk({tag, "_tkeep"},  m_axis_tkeep, 0);
    chk({tag, "_tlast"},  m_axis_tlast, 0);
    chk({tag, "_tuser"},  m_axis_tuser, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_pready"}, pix_ready, 0);
  endtask

  // Reference: split the frame's pixels into groups of PPB, earliest pixel in the low lane.
  task automatic build(int total, bit incr, int base);
    beat_t b;
    pix_q.delete();
    exp_q.delete();
    for (int i = 0; i < total; i++)
      pix_q.push_back(incr ? PIX_W'(base + i) : PIX_W'($urandom));
    for (int i = 0; i < total; i += PPB) begin
      b.d = '0;
      b.k = '0;
      for (int j = 0; j < PPB && i + j < total; j++) begin
        b.d[j*PIX_W +: PIX_W] = pix_q[i+j];
        b.k[j*(PIX_W/8) +: PIX_W/8] = '1;
      end
      b.u = (i == 0);
      b.l = (i + PPB >= total);
      exp_q.push_back(b);
    end
  endtask

  // rmode: 0 always ready, 1 toggling, 2 random. rst_at >= 0 aborts after that many pixels.
  task automatic run_frame(int w, int h, int rmode, bit rnd_valid, bit incr, int base,
                           bit extra_start, int rst_at);
    int            total;
    int            acc, cyc;
    bit            exp_done, done_nxt, finished, aborted, stalled, first;
    logic [DW-1:0] held_d;
    logic [KW-1:0] held_k;
    beat_t         e;
    total = w * h;
    acc = 0; cyc = 0; exp_done = 0; finished = 0; aborted = 0; stalled = 0; first = 1;
    held_d = '0; held_k = '0;
    build(total, incr, base);
    @(negedge role_clk);
    frame_width = DIM_W'(w); frame_height = DIM_W'(h); start = 1'b1;
    pix_valid = 1'b0; m_axis_tready = 1'b0;
    @(negedge role_clk);
    while (!finished && cyc < 3000) begin
      done_nxt = 0;
      start = extra_start && (cyc == 2);
      if (start) begin
        frame_width = DIM_W'($urandom_range(1, 9));
        frame_height = DIM_W'($urandom_range(1, 9));
      end
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      if (pix_q.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
        pix_valid = 1'b1; pix_data = pix_q[0];
      end else begin
        pix_valid = 1'b0; pix_data = PIX_W'($urandom);
      end
      if (rst_at >= 0 && acc == rst_at) begin
        pix_valid = 1'b0;
        role_rst = 1'b1;
        #1 chk_all_zero("abort");
        #2 role_rst = 1'b0;
        aborted = 1;
        break;
      end
      #1;
      if (first) chk("busy_rise", busy, 1);
      first = 0;
      chk("done_timing", done, exp_done);
      if (done) begin
        chk("busy_at_done", busy, 0);
        finished = 1;
      end else begin
        chk("pix_ready_rule", pix_ready,
            (acc < total) && (!m_axis_tvalid || m_axis_tready));
        if (total == 0) chk("zero_no_tvalid", m_axis_tvalid, 0);
        if (stalled) begin
          chk("stall_tvalid", m_axis_tvalid, 1);
          chk("stall_tdata", m_axis_tdata, held_d);
          chk("stall_tkeep", m_axis_tkeep, held_k);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tkeep", m_axis_tkeep, e.k);
            chk("tlast", m_axis_tlast, e.l);
            chk("tuser", m_axis_tuser, e.u);
            if (exp_q.size() == 0) done_nxt = 1;
          end
        end
        if (pix_valid && pix_ready) begin
          void'(pix_q.pop_front());
          acc++;
        end
        if (total == 0 && cyc == 0) done_nxt = 1;
        stalled = m_axis_tvalid && !m_axis_tready;
        held_d = m_axis_tdata;
        held_k = m_axis_tkeep;
      end
      exp_done = done_nxt;
      cyc++;
      if (!finished) @(negedge role_clk);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    if (!aborted) begin
      chk("frame_timeout", finished, 1);
      chk("beats_left", exp_q.size(), 0);
      chk("pix_left", pix_q.size(), 0);
      for (int i = 0; i < (extra_start ? 4 : 1); i++) begin
        @(negedge role_clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_tvalid", m_axis_tvalid, 0);
      end
    end
  endtask

  initial begin
    #1 chk_all_zero("reset");
    @(negedge role_clk);
    role_rst = 1'b0;
    run_frame(4, 2, 0, 0, 1, 8'h01, 0, -1);
    run_frame(3, 3, 0, 0, 1, 8'h10, 0, -1);
    run_frame(8, 4, 1, 0, 0, 0, 0, -1);
    run_frame(0, 5, 0, 0, 0, 0, 0, -1);
    run_frame(4, 4, 2, 1, 0, 0, 1, -1);
    run_frame(4, 4, 0, 0, 1, 8'h40, 0, 5);
    run_frame(4, 1, 0, 0, 1, 8'hA0, 0, -1);
    for (int f = 0; f < 12; f++)
      run_frame($urandom_range(1, 9), $urandom_range(1, 5), 2, 1, 1'($urandom_range(0, 1)),
                $urandom_range(0, 255), 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
